// File: rtl/dtw_traceback.sv
// DTW traceback: walks the warping path from (len_t, len_r) back to (0,0)
// through the path-code RAM, streaming each visited cell most recent first.
module dtw_traceback #(
   parameter int IDX_W = 5,
   parameter int LEN_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IDX_W-1:0]   i_len_t,
   input  logic [IDX_W-1:0]   i_len_r,
   output logic               mem_rd_en,
   output logic [2*IDX_W-1:0] mem_addr,
   input  logic [1:0]         mem_path,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_tindex,
   output logic [IDX_W-1:0]   out_rindex,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [LEN_W-1:0]   o_len
);

   typedef enum logic [2:0] {
      IDLE, EMIT, READ, WAIT, DONE, ERR
   } state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] t, r, t_nx, r_nx;
   logic [LEN_W-1:0] len, len_nx;
   logic             t_zero, r_zero;

   assign t_zero = (t == '0);
   assign r_zero = (r == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         t     <= '0;
         r     <= '0;
         len   <= '0;
      end else begin
         state <= state_nx;
         t     <= t_nx;
         r     <= r_nx;
         len   <= len_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      t_nx      = t;
      r_nx      = r;
      len_nx    = len;
      out_valid = 1'b0;
      out_last  = 1'b0;
      mem_rd_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               t_nx     = i_len_t;
               r_nx     = i_len_r;
               len_nx   = '0;
               state_nx = EMIT;
            end
         end
         EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = t_zero & r_zero;
            if (out_ready) begin
               len_nx = len + LEN_W'(1);
               // Edge cells have only one legal predecessor: skip the RAM.
               if (t_zero && r_zero) begin
                  state_nx = DONE;
               end else if (t_zero) begin
                  r_nx = r - IDX_W'(1);
               end else if (r_zero) begin
                  t_nx = t - IDX_W'(1);
               end else begin
                  state_nx = READ;
               end
            end
         end
         READ: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            state_nx  = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            case (mem_path)
               2'b11: begin
                  t_nx     = t - IDX_W'(1);
                  r_nx     = r - IDX_W'(1);
                  state_nx = EMIT;
               end
               2'b10: begin
                  t_nx     = t - IDX_W'(1);
                  state_nx = EMIT;
               end
               2'b01: begin
                  r_nx     = r - IDX_W'(1);
                  state_nx = EMIT;
               end
               default: state_nx = ERR;
            endcase
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         ERR: begin
            done     = 1'b1;
            err      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_addr   = {t, r};
   assign out_tindex = t;
   assign out_rindex = r;
   assign o_len      = len;

endmodule

// File: tb/tb_dtw_traceback.sv
// Directed bench for dtw_traceback with a 1-cycle-latency path RAM model
// and a negedge monitor that records emitted cells and event counts.
module tb_dtw_traceback;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] i_len_t, i_len_r;
   logic       mem_rd_en;
   logic [9:0] mem_addr;
   logic [1:0] mem_path = 2'b00;
   logic       out_valid, out_ready, out_last;
   logic [4:0] out_tindex, out_rindex;
   logic       busy, done, err;
   logic [5:0] o_len;

   int checks = 0;
   int failures = 0;

   logic [1:0] mem [0:1023];
   int rd_cnt = 0, cell_cnt = 0, busy_cnt = 0;
   int done_cnt = 0, err_cnt = 0, bad_err = 0;
   logic [4:0] ct [0:255];
   logic [4:0] cr [0:255];
   logic       cl [0:255];

   dtw_traceback #(.IDX_W(5), .LEN_W(6)) dut (
      .clk(clk), .rst(rst), .start(start),
      .i_len_t(i_len_t), .i_len_r(i_len_r),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_path(mem_path),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_tindex(out_tindex), .out_rindex(out_rindex),
      .out_last(out_last), .busy(busy), .done(done), .err(err),
      .o_len(o_len)
   );

   always #5 clk = ~clk;

   // Data returned here is stable across the following rising edge (WAIT).
   always @(negedge clk) begin
      if (mem_rd_en) begin
         mem_path <= mem[mem_addr];
         rd_cnt   <= rd_cnt + 1;
      end
      if (out_valid && out_ready) begin
         ct[cell_cnt % 256] <= out_tindex;
         cr[cell_cnt % 256] <= out_rindex;
         cl[cell_cnt % 256] <= out_last;
         cell_cnt <= cell_cnt + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (err && !done) bad_err <= bad_err + 1;
   end

   task automatic fill_mem(input logic [1:0] code);
      for (int a = 0; a < 1024; a++) mem[a] = code;
   endtask

   task automatic do_start(input logic [4:0] lt, input logic [4:0] lr);
      @(posedge clk); #1;
      start = 1'b1; i_len_t = lt; i_len_r = lr;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(posedge clk); #1;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, mem_rd_en, busy, done, err, out_last} !== 6'b0 ||
          o_len !== 6'd0 || out_tindex !== 5'd0 || out_rindex !== 5'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b rd=%b busy=%b done=%b len=%0d exp all 0",
                  out_valid, mem_rd_en, busy, done, o_len);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b v=%b exp 0 0", busy, out_valid);
      end
   endtask

   task automatic test_diag;
      int c0, r0, b0, e0;
      bit ok;
      int et[4] = '{3, 2, 1, 0};
      fill_mem(2'b11);
      out_ready = 1'b1;
      c0 = cell_cnt; r0 = rd_cnt; b0 = busy_cnt; e0 = err_cnt;
      do_start(5'd3, 5'd3);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL diag_busy got=%b exp=1", busy);
      end
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd4 || err !== 1'b0) begin
         failures++;
         $display("FAIL diag_done got ok=%b len=%0d err=%b exp 1 4 0", ok, o_len, err);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || o_len !== 6'd4) begin
         failures++;
         $display("FAIL diag_after got busy=%b done=%b len=%0d exp 0 0 4", busy, done, o_len);
      end
      checks++;
      if (cell_cnt - c0 != 4 || rd_cnt - r0 != 3 || busy_cnt - b0 != 10 || err_cnt != e0) begin
         failures++;
         $display("FAIL diag_counts got cells=%0d reads=%0d busy=%0d exp 4 3 10",
                  cell_cnt - c0, rd_cnt - r0, busy_cnt - b0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ct[(c0+i)%256] !== 5'(et[i]) || cr[(c0+i)%256] !== 5'(et[i]) ||
             cl[(c0+i)%256] !== (i == 3)) begin
            failures++;
            $display("FAIL diag_cell%0d got (%0d,%0d,last=%b) exp (%0d,%0d,last=%b)", i,
                     ct[(c0+i)%256], cr[(c0+i)%256], cl[(c0+i)%256], et[i], et[i], i == 3);
         end
      end
   endtask

   task automatic test_edge;
      int c0, r0, b0;
      bit ok;
      c0 = cell_cnt; r0 = rd_cnt; b0 = busy_cnt;
      do_start(5'd2, 5'd0);
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd3) begin
         failures++;
         $display("FAIL edge_done got ok=%b len=%0d exp 1 3", ok, o_len);
      end
      @(posedge clk); #1;
      checks++;
      if (cell_cnt - c0 != 3 || rd_cnt != r0 || busy_cnt - b0 != 3) begin
         failures++;
         $display("FAIL edge_counts got cells=%0d reads=%0d busy=%0d exp 3 0 3",
                  cell_cnt - c0, rd_cnt - r0, busy_cnt - b0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ct[(c0+i)%256] !== 5'(2 - i) || cr[(c0+i)%256] !== 5'd0 ||
             cl[(c0+i)%256] !== (i == 2)) begin
            failures++;
            $display("FAIL edge_cell%0d got (%0d,%0d,last=%b) exp (%0d,0,last=%b)", i,
                     ct[(c0+i)%256], cr[(c0+i)%256], cl[(c0+i)%256], 2 - i, i == 2);
         end
      end
   endtask

   task automatic test_single;
      int c0, r0;
      bit ok;
      c0 = cell_cnt; r0 = rd_cnt;
      do_start(5'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1) begin
         failures++;
         $display("FAIL single_last got v=%b last=%b exp 1 1", out_valid, out_last);
      end
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd1 || cell_cnt - c0 != 1 || rd_cnt != r0) begin
         failures++;
         $display("FAIL single_done got ok=%b len=%0d cells=%0d reads=%0d exp 1 1 1 0",
                  ok, o_len, cell_cnt - c0, rd_cnt - r0);
      end
   endtask

   task automatic test_mixed;
      int c0, r0, b0;
      bit ok;
      int et[4] = '{2, 1, 1, 0};
      int er[4] = '{2, 2, 1, 0};
      fill_mem(2'b00);
      mem[{5'd2, 5'd2}] = 2'b10;
      mem[{5'd1, 5'd2}] = 2'b01;
      mem[{5'd1, 5'd1}] = 2'b11;
      c0 = cell_cnt; r0 = rd_cnt; b0 = busy_cnt;
      do_start(5'd2, 5'd2);
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd4 || err !== 1'b0) begin
         failures++;
         $display("FAIL mixed_done got ok=%b len=%0d err=%b exp 1 4 0", ok, o_len, err);
      end
      @(posedge clk); #1;
      checks++;
      if (cell_cnt - c0 != 4 || rd_cnt - r0 != 3 || busy_cnt - b0 != 10) begin
         failures++;
         $display("FAIL mixed_counts got cells=%0d reads=%0d busy=%0d exp 4 3 10",
                  cell_cnt - c0, rd_cnt - r0, busy_cnt - b0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ct[(c0+i)%256] !== 5'(et[i]) || cr[(c0+i)%256] !== 5'(er[i])) begin
            failures++;
            $display("FAIL mixed_cell%0d got (%0d,%0d) exp (%0d,%0d)", i,
                     ct[(c0+i)%256], cr[(c0+i)%256], et[i], er[i]);
         end
      end
   endtask

   task automatic test_stall;
      int c0, r0, b0;
      bit ok;
      fill_mem(2'b11);
      out_ready = 1'b0;
      c0 = cell_cnt; r0 = rd_cnt; b0 = busy_cnt;
      do_start(5'd3, 5'd3);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_tindex !== 5'd3 || out_rindex !== 5'd3 ||
             mem_rd_en !== 1'b0 || rd_cnt != r0) begin
            failures++;
            $display("FAIL stall_hold%0d got v=%b t=%0d r=%0d rd=%b exp 1 3 3 0",
                     i, out_valid, out_tindex, out_rindex, mem_rd_en);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd4) begin
         failures++;
         $display("FAIL stall_done got ok=%b len=%0d exp 1 4", ok, o_len);
      end
      @(posedge clk); #1;
      checks++;
      if (cell_cnt - c0 != 4 || rd_cnt - r0 != 3 || busy_cnt - b0 != 15 ||
          ct[c0%256] !== 5'd3 || ct[(c0+3)%256] !== 5'd0 || cl[(c0+3)%256] !== 1'b1) begin
         failures++;
         $display("FAIL stall_seq got cells=%0d reads=%0d busy=%0d exp 4 3 15",
                  cell_cnt - c0, rd_cnt - r0, busy_cnt - b0);
      end
   endtask

   task automatic test_err;
      int c0, r0, d0, e0;
      bit ok;
      fill_mem(2'b00);
      c0 = cell_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
      do_start(5'd2, 5'd2);
      wait_done(ok);
      checks++;
      if (!ok || err !== 1'b1 || o_len !== 6'd1) begin
         failures++;
         $display("FAIL err_pulse got ok=%b err=%b len=%0d exp 1 1 1", ok, err, o_len);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || err !== 1'b0 || cell_cnt - c0 != 1 || rd_cnt - r0 != 1 ||
          done_cnt - d0 != 1 || err_cnt - e0 != 1 || bad_err != 0) begin
         failures++;
         $display("FAIL err_after got busy=%b cells=%0d reads=%0d dones=%0d errs=%0d exp 0 1 1 1 1",
                  busy, cell_cnt - c0, rd_cnt - r0, done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_back_to_back;
      int c0, d0;
      bit ok, seen;
      fill_mem(2'b11);
      out_ready = 1'b1;
      do_start(5'd3, 5'd3);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (mem_rd_en) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      checks++;
      if (!seen || {out_valid, mem_rd_en, busy, done, err} !== 5'b0 ||
          o_len !== 6'd0 || out_tindex !== 5'd0 || out_rindex !== 5'd0) begin
         failures++;
         $display("FAIL abort_outputs got seen=%b v=%b busy=%b len=%0d t=%0d exp 1 0 0 0 0",
                  seen, out_valid, busy, o_len, out_tindex);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_nodone got dones=%0d busy=%b exp 0 0", done_cnt - d0, busy);
      end
      out_ready = 1'b0;
      c0 = cell_cnt;
      do_start(5'd3, 5'd3);
      do_start(5'd1, 5'd1);
      checks++;
      if (out_valid !== 1'b1 || out_tindex !== 5'd3 || out_rindex !== 5'd3) begin
         failures++;
         $display("FAIL ignore_start got v=%b t=%0d r=%0d exp 1 3 3",
                  out_valid, out_tindex, out_rindex);
      end
      out_ready = 1'b1;
      wait_done(ok);
      checks++;
      if (!ok || o_len !== 6'd4 || err !== 1'b0) begin
         failures++;
         $display("FAIL fresh_done got ok=%b len=%0d err=%b exp 1 4 0", ok, o_len, err);
      end
      @(posedge clk); #1;
      checks++;
      if (cell_cnt - c0 != 4 || ct[c0%256] !== 5'd3 || cr[c0%256] !== 5'd3) begin
         failures++;
         $display("FAIL fresh_seq got cells=%0d first=(%0d,%0d) exp 4 (3,3)",
                  cell_cnt - c0, ct[c0%256], cr[c0%256]);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      i_len_t = '0; i_len_r = '0;
      fill_mem(2'b00);
      test_reset;
      test_diag;
      test_edge;
      test_single;
      test_mixed;
      test_stall;
      test_err;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dtw_traceback.md
Name: dtw_traceback

Overview:
- Walks the DTW warping path backwards through the path-code memory written by the processing-element array.
- Starts at the end cell (len_t, len_r) and follows each cell's 2-bit path code until it reaches (0,0).
- Streams the visited (t,r) index pairs over a valid/ready interface, most recent cell first.
- Sits after the PE array and path RAM, and feeds alignment post-processing.

Parameters:
IDX_W, 5, width of the t and r indices (max index 2^IDX_W-1 = 31)
LEN_W, 6, width of the path-length counter (holds up to 2*31+1 = 63)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a traceback; ignored while busy=1
i_len_t  in  IDX_W  last template index (start row); sampled when start is accepted
i_len_r  in  IDX_W  last reference index (start column); sampled when start is accepted
mem_rd_en  out  1  path RAM read strobe
mem_addr  out  2*IDX_W  read address = {t, r}
mem_path  in  2  path code; valid exactly 1 cycle after mem_rd_en
out_valid  out  1  out_tindex/out_rindex hold a path cell
out_ready  in  1  downstream accepts the cell when out_valid & out_ready
out_tindex  out  IDX_W  t coordinate of the current cell
out_rindex  out  IDX_W  r coordinate of the current cell
out_last  out  1  current cell is (0,0); qualified by out_valid
busy  out  1  high from the cycle after start is accepted until the cycle DONE/ERR is entered
done  out  1  one-cycle pulse when the traceback ends, whether normally or with an error
err  out  1  one-cycle pulse coincident with done when an invalid code was read
o_len  out  LEN_W  number of cells emitted; valid in the done cycle, held until the next start

Behaviour:
- Path codes:
  - 2'b11: move to (t-1, r-1).
  - 2'b10: move to (t-1, r).
  - 2'b01: move to (t, r-1).
  - 2'b00: invalid.
- Reset: state IDLE, counters and coordinates 0, all outputs 0.
  - Reset mid-traceback aborts immediately.
  - No done or err pulse follows the abort.
- FSM states: IDLE, EMIT, READ, WAIT, DONE, ERR.
- IDLE:
  - On start, load t=i_len_t, r=i_len_r and o_len=0, then go to EMIT.
  - start in any other state is ignored.
- EMIT:
  - out_valid=1; out_last=1 iff t==0 and r==0.
  - Outputs are held stable until the handshake; out_ready may be low for any number of cycles.
  - On handshake, o_len increments, then:
    - (0,0): go to DONE.
    - t==0, r>0: r<=r-1, back to EMIT. Forced move, no RAM read.
    - r==0, t>0: t<=t-1, back to EMIT. Forced move, no RAM read.
    - Otherwise go to READ.
- READ: mem_rd_en=1 with mem_addr={t,r} for exactly one cycle, then go to WAIT.
- WAIT:
  - Sample mem_path and decode it.
  - Valid code: update t/r per the table, then go to EMIT.
  - 2'b00: go to ERR; t/r are left unchanged.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and err=1 for one cycle, then IDLE.
- Both DONE and ERR drop busy.
- mem_rd_en is 0 in every state except READ.
- Throughput:
  - An interior step takes 3 cycles (EMIT, READ, WAIT) with out_ready held high.
  - An edge (forced) step takes 1 cycle.
- i_len_t=i_len_r=0: a single cell (0,0) is emitted with out_last=1, and o_len=1.
- Arithmetic: t and r only decrement, never below 0, because the edge rules guarantee it.
- o_len on success equals i_len_t+i_len_r+1 minus the number of diagonal moves.

Test Plan:
- All-diagonal RAM (every code 11), start with len 3/3 -> cells (3,3),(2,2),(1,1),(0,0); out_last only on the 4th; o_len=4; 3 RAM reads; done pulses, err=0.
- len_t=2, len_r=0 -> cells (2,0),(1,0),(0,0); mem_rd_en never asserted; o_len=3.
- Mixed RAM: (2,2)=10, (1,2)=01, (1,1)=11, start 2/2 -> cells (2,2),(1,2),(1,1),(0,0); o_len=4.
- out_ready low for 5 cycles during EMIT at (3,3) -> out_valid stays 1 and coordinates are stable; no RAM read until the handshake; sequence is otherwise identical.
- (2,2)=00, start 2/2 -> (2,2) emitted, then 1 read, then done=1 and err=1 in the same cycle; o_len=1; busy=0 afterwards.
- rst pulsed during WAIT -> all outputs 0 immediately, no done pulse; start pulsed during EMIT is ignored; a fresh start after reset runs normally.
